cordic_polar: RTL and testbench
===============================

# cordic_polar

Iterative vectoring-CORDIC that converts the demodulated, low-pass-filtered quadrature pair (X, Y) of the lock-in into magnitude R and phase φ. It sits directly downstream of the two low-pass filter instances (in-phase and quadrature channel). It samples their outputs on a request strobe and delivers one polar result per request to the readout registers.

## Interface
- AXIS_TDATA_WIDTH, 32: width of X/Y inputs and R/φ outputs (signed two's complement)
- ITER, 24: number of CORDIC micro-rotations, legal range 8..30
- clk_i  in  1  clock; all logic on rising edge
- rstn_i  in  1  reset; synchronous, active-low
- x_i  in  AXIS_TDATA_WIDTH  in-phase LPF output, signed
- y_i  in  AXIS_TDATA_WIDTH  quadrature LPF output, signed
- valid_i  in  1  request strobe; x_i/y_i sampled when high and block idle
- r_o  out  AXIS_TDATA_WIDTH  magnitude, non-negative, saturating at 0x7FFFFFFF
- phi_o  out  AXIS_TDATA_WIDTH  phase, binary angle: 0x80000000 = −π, 0x40000000 = +π/2, LSB = π/2^31
- valid_o  out  1  one-cycle pulse when r_o/phi_o update
- busy_o  out  1  high from capture until the valid_o cycle inclusive
- ovr_o  out  1  sticky: valid_i arrived while busy; cleared only by reset

## Operation
- States: IDLE, ROT, SCALE (present only with macro, see Configuration), DONE.
- IDLE: on valid_i=1, capture into internal x, y, z registers of width AXIS_TDATA_WIDTH+2. Apply the quadrant pre-rotation in the same edge:
  - x_i ≥ 0: x=x_i, y=y_i, z=0.
  - x_i < 0 and y_i ≥ 0: x=−x_i, y=−y_i, z=0x80000000 (+π, wraps).
  - x_i < 0 and y_i < 0: same negation, z=0x80000000 (−π).
  - Go to ROT with iteration counter i=0.
- ROT, iteration i:
  - If y<0: x ← x − (y>>>i), y ← y + (x>>>i), z ← z − atan_i.
  - Otherwise: x ← x + (y>>>i), y ← y − (x>>>i), z ← z + atan_i.
  - atan_i = round(atan(2^−i)/π · 2^31), from a constant ROM (atan_0 = 0x20000000).
  - Arithmetic shifts. z wraps modulo 2^32.
  - At i=ITER−1, go to SCALE (macro set) or DONE.
- SCALE: x ← (x · K) >>> 31 with K = 0x4DBA76D4 (0.6072529, Q1.31), rounding half-up.
- DONE: register outputs:
  - r_o = x saturated to [0, 0x7FFFFFFF].
  - phi_o = z.
  - valid_o=1 for this cycle only.
  - Return to IDLE.
- Overrun: valid_i=1 in any state other than IDLE sets ovr_o. The request is dropped and the running computation is unaffected.
- valid_i in the same cycle as DONE counts as overrun. The next request is accepted in the cycle after valid_o.
- Zero input (x=y=0): r_o=0, phi_o=0.

## Timing
- Reset values: r_o=0, phi_o=0, valid_o=0, busy_o=0, ovr_o=0, state IDLE.
- Latency, counted from the edge sampling valid_i to the edge raising valid_o: ITER+1 cycles without macro, ITER+2 with.
- Throughput: one result per ITER+2 (ITER+3 with macro) cycles.
- busy_o rises on the capture edge and falls on the edge after valid_o.
- r_o/phi_o hold their values between valid_o pulses.
- Reset asserted mid-computation: on the next edge all state returns to reset values. No valid_o is produced for the aborted request.

## Configuration
- CORDIC_GAIN_COMP_EN defined: SCALE state and the K multiplier are built. r_o ≈ √(X²+Y²).
- CORDIC_GAIN_COMP_EN undefined: no multiplier and no SCALE state. r_o ≈ 1.64676·√(X²+Y²), saturating; latency reduced by one cycle.
- phi_o is identical in both builds.

## Test plan
- X=0x10000000, Y=0, macro set → r_o=0x10000000 ±4, phi_o=0x00000000 ±128, valid_o at capture+ITER+2.
- X=Y=0x10000000 → r_o=0x16A09E66 ±4, phi_o=0x20000000 ±128.
- X=0, Y=−0x20000000 → r_o=0x20000000 ±4, phi_o=0xC0000000 ±128. Then X=−0x10000000, Y=0 → phi_o=0x80000000 ±128.
- X=Y=0x7FFFFFFF, macro unset → r_o=0x7FFFFFFF (saturated), phi_o=0x20000000 ±128, valid_o at capture+ITER+1.
- valid_i held high for 3 cycles → exactly one valid_o, ovr_o=1 from the second cycle and held until rstn_i=0.
- rstn_i=0 for one cycle at iteration 10 → busy_o=0 next cycle, no valid_o; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/cordic_polar.sv
// Iterative vectoring CORDIC: converts the filtered (X, Y) pair into magnitude r_o and binary-angle phi_o.
// Optional macro CORDIC_GAIN_COMP_EN adds a SCALE state that removes the CORDIC gain from r_o.
module cordic_polar #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ITER             = 24
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [AXIS_TDATA_WIDTH-1:0] x_i,
  input  logic [AXIS_TDATA_WIDTH-1:0] y_i,
  input  logic                        valid_i,
  output logic [AXIS_TDATA_WIDTH-1:0] r_o,
  output logic [AXIS_TDATA_WIDTH-1:0] phi_o,
  output logic                        valid_o,
  output logic                        busy_o,
  output logic                        ovr_o
);

  localparam int unsigned W  = AXIS_TDATA_WIDTH;
  localparam int unsigned IW = W + 2;
  localparam logic [4:0] LastIter = 5'(ITER - 1);

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {StIdle, StRot, StScale, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;
`endif

  state_e state_q, state_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, xs, ys, x_ext, y_ext;
  logic [W-1:0] z_q, z_d, r_q, r_d, phi_q, phi_d, atan_w, r_sat;
  logic [4:0] cnt_q, cnt_d;
  logic zero_q, zero_d, valid_q, valid_d, ovr_q, ovr_d;

  // atan(2^-i) in units of pi/2^31, rounded to nearest.
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_rom = 32'h2000_0000;
      5'd1:  atan_rom = 32'h12E4_051E;
      5'd2:  atan_rom = 32'h09FB_385B;
      5'd3:  atan_rom = 32'h0511_11D4;
      5'd4:  atan_rom = 32'h028B_0D43;
      5'd5:  atan_rom = 32'h0145_D7E1;
      5'd6:  atan_rom = 32'h00A2_F61E;
      5'd7:  atan_rom = 32'h0051_7C55;
      5'd8:  atan_rom = 32'h0028_BE53;
      5'd9:  atan_rom = 32'h0014_5F2F;
      5'd10: atan_rom = 32'h000A_2F98;
      5'd11: atan_rom = 32'h0005_17CC;
      5'd12: atan_rom = 32'h0002_8BE6;
      5'd13: atan_rom = 32'h0001_45F3;
      5'd14: atan_rom = 32'h0000_A2FA;
      5'd15: atan_rom = 32'h0000_517D;
      5'd16: atan_rom = 32'h0000_28BE;
      5'd17: atan_rom = 32'h0000_145F;
      5'd18: atan_rom = 32'h0000_0A30;
      5'd19: atan_rom = 32'h0000_0518;
      5'd20: atan_rom = 32'h0000_028C;
      5'd21: atan_rom = 32'h0000_0146;
      5'd22: atan_rom = 32'h0000_00A3;
      5'd23: atan_rom = 32'h0000_0051;
      5'd24: atan_rom = 32'h0000_0029;
      5'd25: atan_rom = 32'h0000_0014;
      5'd26: atan_rom = 32'h0000_000A;
      5'd27: atan_rom = 32'h0000_0005;
      5'd28: atan_rom = 32'h0000_0003;
      5'd29: atan_rom = 32'h0000_0001;
      default: atan_rom = 32'h0000_0000;
    endcase
  endfunction

  assign x_ext  = {{2{x_i[W-1]}}, x_i};
  assign y_ext  = {{2{y_i[W-1]}}, y_i};
  assign xs     = x_q >>> cnt_q;
  assign ys     = y_q >>> cnt_q;
  assign atan_w = W'(atan_rom(cnt_q));

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [32:0] GainK = 33'sh0_4DBA_76D4;
  logic signed [IW+32:0] prod;
  assign prod = x_q * GainK + $signed((IW + 33)'(2 ** 30));
`endif

  always_comb begin
    if (x_q[IW-1]) begin
      r_sat = '0;
    end else if (|x_q[IW-2:W-1]) begin
      r_sat = {1'b0, {(W-1){1'b1}}};
    end else begin
      r_sat = x_q[W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    r_d     = r_q;
    phi_d   = phi_q;
    valid_d = 1'b0;
    // Requests outside IDLE are dropped but remembered.
    ovr_d   = ovr_q | (valid_i && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          // Fold the left half-plane onto the right so the rotations always converge.
          if (x_i[W-1]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = W'(32'h8000_0000);
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end
          zero_d  = (x_i == '0) && (y_i == '0);
          cnt_d   = '0;
          state_d = StRot;
        end
      end
      StRot: begin
        if (y_q[IW-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_w;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_w;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = StScale;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      StScale: begin
        x_d     = prod[IW+30:31];
        state_d = StDone;
      end
`endif
      StDone: begin
        r_d     = r_sat;
        phi_d   = zero_q ? '0 : z_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      r_q     <= '0;
      phi_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      r_q     <= r_d;
      phi_q   <= phi_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign r_o     = r_q;
  assign phi_o   = phi_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != StIdle) || valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_cordic_polar.sv
// Self-checking bench for cordic_polar: results compared against a real-arithmetic polar model.
module tb_cordic_polar;
  localparam int NITER = 24;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = NITER + 2;
  localparam int RTOL = 4;
`else
  localparam int LAT  = NITER + 1;
  localparam int RTOL = 8;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x_in, y_in;
  logic        valid_in;
  logic [31:0] r, phi;
  logic        valid_out, busy, ovr;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  real gain;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_polar #(.AXIS_TDATA_WIDTH(32), .ITER(NITER)) dut (
    .clk_i(clk), .rstn_i(rstn), .x_i(x_in), .y_i(y_in), .valid_i(valid_in),
    .r_o(r), .phi_o(phi), .valid_o(valid_out), .busy_o(busy), .ovr_o(ovr)
  );

  // Ideal polar conversion; magnitude carries the CORDIC gain when it is not compensated.
  task automatic model(input logic [31:0] xv, input logic [31:0] yv, input int tol_in,
                       output logic [31:0] r_exp, output int r_tol, output logic [31:0] p_exp);
    int xi, yi;
    real xr, yr, mag, ang;
    longint ml, al;
    xi = $signed(xv);
    yi = $signed(yv);
    xr = $itor(xi);
    yr = $itor(yi);
    mag = $sqrt(xr * xr + yr * yr);
`ifndef CORDIC_GAIN_COMP_EN
    mag = mag * gain;
`endif
    if (mag > 2147483647.0 + 64.0) begin
      r_exp = 32'h7FFF_FFFF;
      r_tol = 0;
    end else begin
      ml = longint'(mag);
      if (ml > 64'sd2147483647) ml = 64'sd2147483647;
      r_exp = ml[31:0];
      r_tol = tol_in;
    end
    ang = $atan2(yr, xr) / 3.14159265358979323846 * 2147483648.0;
    al = longint'(ang);
    p_exp = al[31:0];
  endtask

  task automatic run_req(input logic [31:0] xv, input logic [31:0] yv,
                         output logic [31:0] rv, output logic [31:0] pv, output int lat);
    @(negedge clk);
    x_in = xv;
    y_in = yv;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = -1;
    rv = '0;
    pv = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        lat = k;
        rv = r;
        pv = phi;
        break;
      end
    end
  endtask

  function automatic int abs_diff32(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = int'(a - b);
    return (d < 0) ? -d : d;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    valid_in = 1'b0;
    x_in = '0;
    y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({r, phi, valid_out, busy, ovr} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state got r=%h phi=%h v=%b b=%b o=%b want all zero",
               r, phi, valid_out, busy, ovr);
    end
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] xs [7];
    logic [31:0] ys [7];
    logic [31:0] rv, pv, r_exp, p_exp;
    int lat, r_tol, p_tol;
    xs = '{32'h1000_0000, 32'h1000_0000, 32'h0000_0000, 32'hF000_0000,
           32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    ys = '{32'h0000_0000, 32'h1000_0000, 32'hE000_0000, 32'h0000_0000,
           32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    for (int i = 0; i < 7; i++) begin
      run_req(xs[i], ys[i], rv, pv, lat);
      model(xs[i], ys[i], RTOL, r_exp, r_tol, p_exp);
      p_tol = 128;
      if (xs[i] == 32'h0 && ys[i] == 32'h0) begin
        r_tol = 0;
        p_tol = 0;
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT);
      end
      checks++;
      if (abs_diff32(rv, r_exp) > r_tol) begin
        errors++;
        $display("FAIL dir%0d_r got=%h want=%h tol=%0d", i, rv, r_exp, r_tol);
      end
      checks++;
      if (abs_diff32(pv, p_exp) > p_tol) begin
        errors++;
        $display("FAIL dir%0d_phi got=%h want=%h tol=%0d", i, pv, p_exp, p_tol);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rv, pv, r_exp, p_exp;
    int lat, r_tol, xi, yi;
    for (int i = 0; i < 16; i++) begin
      xi = int'($urandom_range(32'h7FFF_FFFF)) - 32'sh4000_0000;
      yi = int'($urandom_range(32'h7FFF_FFFF)) - 32'sh4000_0000;
      // Keep the vector long enough that phase resolution is not limited by LSB noise.
      if (xi < 32'sh1000_0000 && xi > -32'sh1000_0000 &&
          yi < 32'sh1000_0000 && yi > -32'sh1000_0000)
        xi = (xi < 0) ? xi - 32'sh1000_0000 : xi + 32'sh1000_0000;
      run_req(xi, yi, rv, pv, lat);
      model(xi, yi, 16, r_exp, r_tol, p_exp);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, LAT);
      end
      checks++;
      if (abs_diff32(rv, r_exp) > r_tol) begin
        errors++;
        $display("FAIL rnd%0d_r x=%h y=%h got=%h want=%h", i, xi, yi, rv, r_exp);
      end
      checks++;
      if (abs_diff32(pv, p_exp) > 160) begin
        errors++;
        $display("FAIL rnd%0d_phi x=%h y=%h got=%h want=%h", i, xi, yi, pv, p_exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rv, pv, r_exp, p_exp;
    int lat, r_tol, c1, c2;
    run_req(32'h1000_0000, 32'h1000_0000, rv, pv, lat);
    c1 = cyc;
    // Issued during the valid_o cycle: must be accepted without overrun.
    run_req(32'h0800_0000, 32'hF800_0000, rv, pv, lat);
    c2 = cyc;
    model(32'h0800_0000, 32'hF800_0000, RTOL, r_exp, r_tol, p_exp);
    checks++;
    if (c2 - c1 !== LAT + 1) begin
      errors++;
      $display("FAIL b2b_period got=%0d want=%0d", c2 - c1, LAT + 1);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_overrun got=%b want=0", ovr);
    end
    checks++;
    if (abs_diff32(pv, p_exp) > 128 || abs_diff32(rv, r_exp) > r_tol) begin
      errors++;
      $display("FAIL b2b_result got r=%h phi=%h want r=%h phi=%h", rv, pv, r_exp, p_exp);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (r !== rv || phi !== pv || valid_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold got r=%h phi=%h v=%b b=%b want r=%h phi=%h v=0 b=0",
               r, phi, valid_out, busy, rv, pv);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] r_exp, p_exp, rv, pv;
    int r_tol, pulses;
    @(negedge clk);
    x_in = 32'h1000_0000;
    y_in = 32'h0;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ovr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_capture got ovr=%b busy=%b want ovr=0 busy=1", ovr, busy);
    end
    x_in = 32'h0;
    y_in = 32'h4000_0000;
    @(posedge clk);
    #1;
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got=%b want=1", ovr);
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    pulses = 0;
    rv = '0;
    pv = '0;
    for (int k = 3; k <= LAT + 10; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        pulses++;
        rv = r;
        pv = phi;
      end
    end
    model(32'h1000_0000, 32'h0, RTOL, r_exp, r_tol, p_exp);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ovr_pulses got=%0d want=1", pulses);
    end
    checks++;
    if (abs_diff32(rv, r_exp) > r_tol || abs_diff32(pv, p_exp) > 128) begin
      errors++;
      $display("FAIL ovr_result got r=%h phi=%h want r=%h phi=%h", rv, pv, r_exp, p_exp);
    end
    checks++;
    if (ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got=%b want=1", ovr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rv, pv, r_exp, p_exp;
    int lat, r_tol, pulses;
    @(negedge clk);
    x_in = 32'h2000_0000;
    y_in = 32'h1000_0000;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({r, phi, valid_out, busy, ovr} !== 67'd0) begin
      errors++;
      $display("FAIL mid_reset got r=%h phi=%h v=%b b=%b o=%b want all zero",
               r, phi, valid_out, busy, ovr);
    end
    rstn = 1'b1;
    pulses = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_valid got=%0d want=0", pulses);
    end
    run_req(32'hE000_0000, 32'h3000_0000, rv, pv, lat);
    model(32'hE000_0000, 32'h3000_0000, RTOL, r_exp, r_tol, p_exp);
    checks++;
    if (lat !== LAT || abs_diff32(rv, r_exp) > r_tol || abs_diff32(pv, p_exp) > 128) begin
      errors++;
      $display("FAIL after_reset got lat=%0d r=%h phi=%h want lat=%0d r=%h phi=%h",
               lat, rv, pv, LAT, r_exp, p_exp);
    end
  endtask

  initial begin
    real p;
    gain = 1.0;
    p = 1.0;
    for (int i = 0; i < NITER; i++) begin
      gain = gain * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
